esp32_spi_rx: RTL and testbench

Oversampling SPI slave that receives the ESP32's OLED SPI traffic (CSn on wifi_gpio17, SCK on sd_clk, MOSI on sd_cmd, D/C on wifi_gpio16) in the clk_25MHz domain. It sits directly downstream of the FTDI/ESP32 passthrough and turns its raw pin-level SPI into a byte stream with a valid/ready handshake, tagged with D/C and frame-start flags. It also serves the button-state byte back to the ESP32 on MISO (sd_d[0]).

---
 rtl/esp32_spi_pkg.sv | 14 +
 rtl/esp32_spi_fifo.sv | 48 ++++
 rtl/esp32_spi_rx.sv | 144 ++++++++++++++
 tb/tb_esp32_spi_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_spi_pkg.sv
// Shared constants and the FIFO entry layout for the ESP32 OLED SPI receiver.
package esp32_spi_pkg;

    localparam int ENTRY_W      = 10;
    localparam int BITCNT_W     = 3;
    localparam int SCK_HALF_MIN = 4;

    typedef struct packed {
        logic       first;
        logic       dc;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/esp32_spi_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is presented whenever not empty.
module esp32_spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/esp32_spi_rx.sv
// Oversampling SPI slave: turns the ESP32 OLED pin traffic into a tagged byte stream
// and shifts the button byte back out on MISO.
module esp32_spi_rx
    import esp32_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic [6:0] btn,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] out_data,
    output logic       out_dc,
    output logic       out_first,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       frame_active
);

    localparam int IN_W = 11;
    // CSn idles high so a reset never looks like the start of a frame.
    localparam logic [IN_W-1:0] SYNC_RST = 11'h400;
    localparam logic [BITCNT_W-1:0] BIT_ONE = {{(BITCNT_W-1){1'b0}}, 1'b1};

    logic [1:0]                        rst_sync_reg;
    logic                              rst_int_n;
    logic [SYNC_STAGES-1:0][IN_W-1:0]  sync_reg;
    logic [IN_W-1:0]                   pins;
    logic [IN_W-1:0]                   pins_s;
    logic                              csn_s, clk_s, mosi_s, dc_s;
    logic [6:0]                        btn_s;
    logic                              csn_prev_reg, clk_prev_reg;
    logic                              csn_fall, csn_rise, sck_rise;

    logic [BITCNT_W-1:0]               bitcnt_reg;
    logic [6:0]                        shift_reg;
    logic                              first_reg;
    logic                              push_reg;
    rx_entry_t                         entry_reg;
    logic [7:0]                        miso_sr_reg;
    logic                              overflow_reg;

    rx_entry_t                         head;
    logic                              fifo_full;
    logic                              fifo_empty;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) rst_sync_reg <= '0;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    assign pins = {spi_csn, spi_clk, spi_mosi, spi_dc, btn};

    always_ff @(posedge clk_25MHz or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_reg     <= {SYNC_STAGES{SYNC_RST}};
            csn_prev_reg <= 1'b1;
            clk_prev_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], pins};
            csn_prev_reg <= csn_s;
            clk_prev_reg <= clk_s;
        end
    end

    assign pins_s = sync_reg[SYNC_STAGES-1];
    assign csn_s  = pins_s[10];
    assign clk_s  = pins_s[9];
    assign mosi_s = pins_s[8];
    assign dc_s   = pins_s[7];
    assign btn_s  = pins_s[6:0];

    assign csn_fall = ~csn_s & csn_prev_reg;
    assign csn_rise = csn_s & ~csn_prev_reg;
    // Gating on csn_s low also makes a coincident CSn rise win over the SCK rise.
    assign sck_rise = clk_s & ~clk_prev_reg & ~csn_s;

    always_ff @(posedge clk_25MHz or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bitcnt_reg  <= '0;
            shift_reg   <= '0;
            first_reg   <= 1'b0;
            push_reg    <= 1'b0;
            entry_reg   <= '0;
            miso_sr_reg <= '0;
        end else begin
            push_reg <= 1'b0;
            if (csn_fall) begin
                bitcnt_reg  <= '0;
                first_reg   <= 1'b1;
                miso_sr_reg <= {1'b0, btn_s};
            end else if (csn_rise) begin
                bitcnt_reg <= '0;
            end else if (sck_rise) begin
                shift_reg   <= {shift_reg[5:0], mosi_s};
                bitcnt_reg  <= bitcnt_reg + BIT_ONE;
                miso_sr_reg <= {miso_sr_reg[6:0], 1'b0};
                if (bitcnt_reg == '1) begin
                    push_reg  <= 1'b1;
                    entry_reg <= {first_reg, dc_s, shift_reg, mosi_s};
                    first_reg <= 1'b0;
                end
            end
        end
    end

    // The FIFO is full only if non-empty, so a stalled consumer means the byte is lost.
    always_ff @(posedge clk_25MHz or negedge rst_int_n) begin
        if (!rst_int_n)                               overflow_reg <= 1'b0;
        else if (push_reg && fifo_full && !out_ready) overflow_reg <= 1'b1;
    end

    esp32_spi_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_25MHz),
        .rst_n     (rst_int_n),
        .push      (push_reg),
        .push_data (entry_reg),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_data     = head.data;
    assign out_dc       = head.dc;
    assign out_first    = head.first;
    assign out_valid    = ~fifo_empty;
    assign overflow     = overflow_reg;
    assign spi_miso     = miso_sr_reg[7];
    assign spi_miso_oe  = ~csn_s;
    assign frame_active = ~csn_s;

endmodule

// File: tb/tb_esp32_spi_rx.sv
// Directed bench for esp32_spi_rx: SPI frames at 3.125 MHz SCK, MISO readback,
// abort, overflow and randomized backpressure.
module tb_esp32_spi_rx;

    logic       clk_25MHz = 1'b0;
    logic       rst_n;
    logic       spi_csn, spi_clk, spi_mosi, spi_dc;
    logic [6:0] btn;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] out_data;
    logic       out_dc, out_first, out_valid, out_ready;
    logic       overflow, frame_active;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] rx_q[$];
    logic [7:0] miso_cap;
    bit         bp_mode = 0;
    logic       stall_prev = 1'b0;
    logic [9:0] held = '0;

    esp32_spi_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .spi_csn      (spi_csn),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_dc       (spi_dc),
        .btn          (btn),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .out_data     (out_data),
        .out_dc       (out_dc),
        .out_first    (out_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .frame_active (frame_active)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_25MHz);
            #1;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dcv, input int nbits, input bit lat);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = d[7-i];
            spi_dc   = dcv;
            cyc(4);
            miso_cap = {miso_cap[6:0], spi_miso};
            spi_clk  = 1'b1;
            if (lat && i == 7) begin
                cyc(3);
                chk("lat_not_yet", 32'(out_valid), 32'd0);
                cyc(1);
                chk("lat_valid", 32'(out_valid), 32'd1);
                chk("lat_data", 32'(out_data), 32'(d));
                chk("lat_first", 32'(out_first), 32'd1);
            end else begin
                cyc(4);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_csn = 1'b0;
        cyc(4);
    endtask

    task automatic frame_end();
        cyc(4);
        spi_csn = 1'b1;
        cyc(8);
    endtask

    task automatic expect_rx(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = 'x;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"},  32'(spi_miso), 32'd0);
        chk({tag, "_oe"},    32'(spi_miso_oe), 32'd0);
        chk({tag, "_data"},  32'(out_data), 32'd0);
        chk({tag, "_dc"},    32'(out_dc), 32'd0);
        chk({tag, "_first"}, 32'(out_first), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_fa"},    32'(frame_active), 32'd0);
    endtask

    // Consumer-side monitor: logs accepted bytes, checks stall stability and OE tracking.
    always @(negedge clk_25MHz) begin
        if (stall_prev) begin
            tests++;
            assert (out_valid === 1'b1 && {out_first, out_dc, out_data} === held) else begin
                fails++;
                $error("FAIL stall_stable: observed %0h/%0b expected %0h/1",
                       {out_first, out_dc, out_data}, out_valid, held);
            end
        end
        tests++;
        assert (spi_miso_oe === frame_active) else begin
            fails++;
            $error("FAIL oe_tracks_fa: observed %0b expected %0b", spi_miso_oe, frame_active);
        end
        if (out_valid && out_ready) begin
            rx_q.push_back({out_first, out_dc, out_data});
            $display("[TB] rx first=%0b dc=%0b data=%02h", out_first, out_dc, out_data);
        end
        stall_prev = out_valid & ~out_ready;
        held       = {out_first, out_dc, out_data};
    end

    initial begin
        logic [7:0] bd;
        rst_n     = 1'b0;
        spi_csn   = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        spi_dc    = 1'b0;
        btn       = '0;
        out_ready = 1'b1;
        miso_cap  = '0;

        // Reset state
        cyc(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        cyc(4);

        // Reset asserted during bit 4 of a frame
        frame_start();
        send_byte(8'hFF, 1'b1, 4, 0);
        spi_mosi = 1'b1;
        cyc(4);
        spi_clk = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        spi_clk = 1'b0;
        spi_csn = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        chk("midrst_q_empty", 32'(rx_q.size()), 32'd0);
        frame_start();
        send_byte(8'hA5, 1'b1, 8, 0);
        frame_end();
        expect_rx("after_rst_A5", 10'h3A5);

        // Two-byte frame with D/C change and first-byte latency
        frame_start();
        send_byte(8'h3C, 1'b0, 8, 1);
        send_byte(8'h81, 1'b1, 8, 0);
        frame_end();
        expect_rx("frame_3C", 10'h23C);
        expect_rx("frame_81", 10'h181);
        chk("frame_q_empty", 32'(rx_q.size()), 32'd0);

        // Button byte on MISO
        btn = 7'b1010011;
        cyc(4);
        miso_cap = '0;
        spi_csn = 1'b0;
        cyc(1);
        chk("fa_lag", 32'(frame_active), 32'd0);
        cyc(1);
        chk("fa_on", 32'(frame_active), 32'd1);
        chk("oe_on", 32'(spi_miso_oe), 32'd1);
        cyc(2);
        send_byte(8'h00, 1'b0, 8, 0);
        chk("miso_byte", 32'(miso_cap), 32'h53);
        chk("miso_drained", 32'(spi_miso), 32'd0);
        frame_end();
        chk("fa_off", 32'(frame_active), 32'd0);
        chk("oe_off", 32'(spi_miso_oe), 32'd0);
        expect_rx("miso_frame_rx", 10'h200);

        // CSn rises after 5 bits, then a clean 0xFF frame
        frame_start();
        send_byte(8'hAA, 1'b1, 5, 0);
        frame_end();
        chk("abort_no_push", 32'(rx_q.size()), 32'd0);
        frame_start();
        send_byte(8'hFF, 1'b0, 8, 0);
        frame_end();
        expect_rx("abort_then_FF", 10'h2FF);
        chk("abort_q_empty", 32'(rx_q.size()), 32'd0);

        // Overflow: FIFO_DEPTH+1 bytes with the consumer stalled
        out_ready = 1'b0;
        frame_start();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk("ovf_before", 32'(overflow), 32'd0);
            send_byte(8'(k + 1), 1'b0, 8, 0);
        end
        frame_end();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head_valid", 32'(out_valid), 32'd1);
        chk("ovf_head_data", 32'(out_data), 32'h01);
        chk("ovf_none_popped", 32'(rx_q.size()), 32'd0);
        out_ready = 1'b1;
        cyc(8);
        expect_rx("ovf_01", 10'h201);
        expect_rx("ovf_02", 10'h002);
        expect_rx("ovf_03", 10'h003);
        expect_rx("ovf_04", 10'h004);
        chk("ovf_05_dropped", 32'(rx_q.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drained", 32'(out_valid), 32'd0);

        // Randomized backpressure across 16 bytes
        bp_mode = 1;
        frame_start();
        for (int k = 0; k < 16; k++) begin
            bd = 8'(k * 29 + 7);
            send_byte(bd, k[0], 8, 0);
        end
        frame_end();
        bp_mode   = 0;
        out_ready = 1'b1;
        cyc(10);
        chk("bp_count", 32'(rx_q.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            bd = 8'(k * 29 + 7);
            expect_rx($sformatf("bp_%0d", k), {(k == 0), k[0], bd});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
